// File: rtl/exponential_envelope.sv
// Exponential amplitude envelope for the note player.
// Walks a parameter-derived exponential table (index 0 = loudest) through
// attack, sustain and release phases. Steps are paced by a prescaler that
// counts audio sample strobes.
module exponential_envelope #(
    parameter int ADDR_W = 4,
    parameter int DOUT_W = 8,
    parameter int RATE_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              note_start,
    input  logic              note_hold,
    input  logic              sample_ready,
    input  logic [RATE_W-1:0] attack_rate,
    input  logic [RATE_W-1:0] release_rate,
    output logic [DOUT_W-1:0] scale,
    output logic [ADDR_W-1:0] index,
    output logic              active,
    output logic              done
);

    localparam int                DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] IDX_MAX = ADDR_W'(DEPTH - 1);
    localparam logic [DOUT_W-1:0] MAXV    = '1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ATTACK  = 2'd1;
    localparam logic [1:0] ST_SUSTAIN = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    // Exponential table: even entries halve each pair, odd entries sit at
    // 3/4 of the preceding even entry. Entry 0 would be full scale, so it
    // saturates to MAXV.
    logic [DOUT_W-1:0] table_w [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_table
            localparam int SH = ((gi % 2) == 0) ? (gi / 2) : (gi / 2 + 2);
            localparam logic [DOUT_W+1:0] BASE = ((gi % 2) == 0)
                ? ((DOUT_W+2)'(1) << DOUT_W)
                : ((DOUT_W+2)'(3) << DOUT_W);
            localparam logic [DOUT_W+1:0] RAW = BASE >> SH;
            assign table_w[gi] = (RAW > (DOUT_W+2)'(MAXV)) ? MAXV : RAW[DOUT_W-1:0];
        end
    endgenerate

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] index_q, index_d;
    logic [RATE_W-1:0] presc_q, presc_d;
    logic [RATE_W-1:0] atk_rate_q, atk_rate_d;
    logic [RATE_W-1:0] rel_rate_q, rel_rate_d;
    logic [DOUT_W-1:0] scale_q, scale_d;
    logic              active_q, active_d;
    logic              done_q, done_d;

    logic [RATE_W-1:0] cur_rate;
    logic              step;

    // Next-state logic: note_start dominates, then prescaler steps, then hold changes.
    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        presc_d    = presc_q;
        atk_rate_d = atk_rate_q;
        rel_rate_d = rel_rate_q;
        done_d     = 1'b0;

        cur_rate = (state_q == ST_RELEASE) ? rel_rate_q : atk_rate_q;
        step     = sample_ready && (presc_q == cur_rate);

        if (note_start) begin
            // Start or retrigger: keep the current index so the level does not jump.
            state_d    = ST_ATTACK;
            presc_d    = '0;
            atk_rate_d = attack_rate;
            rel_rate_d = release_rate;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    index_d = IDX_MAX;
                end
                ST_ATTACK: begin
                    if (index_q == '0) begin
                        // Retriggered while already at full level.
                        state_d = note_hold ? ST_SUSTAIN : ST_RELEASE;
                        presc_d = '0;
                    end else if (sample_ready) begin
                        if (step) begin
                            presc_d = '0;
                            index_d = index_q - ADDR_W'(1);
                            if (index_q == ADDR_W'(1)) begin
                                state_d = note_hold ? ST_SUSTAIN : ST_RELEASE;
                            end
                        end else begin
                            presc_d = presc_q + RATE_W'(1);
                        end
                    end
                end
                ST_SUSTAIN: begin
                    index_d = '0;
                    if (!note_hold) begin
                        state_d = ST_RELEASE;
                        presc_d = '0;
                    end
                end
                default: begin
                    if (sample_ready) begin
                        if (step) begin
                            presc_d = '0;
                            if (index_q == IDX_MAX) begin
                                state_d = ST_IDLE;
                                done_d  = 1'b1;
                            end else begin
                                index_d = index_q + ADDR_W'(1);
                            end
                        end else begin
                            presc_d = presc_q + RATE_W'(1);
                        end
                    end
                end
            endcase
        end

        active_d = (state_d != ST_IDLE);
        // Scale trails state/index by one cycle, like a synchronous ROM read.
        scale_d  = (state_q != ST_IDLE) ? table_w[index_q] : '0;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            index_q    <= IDX_MAX;
            presc_q    <= '0;
            atk_rate_q <= '0;
            rel_rate_q <= '0;
            scale_q    <= '0;
            active_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            presc_q    <= presc_d;
            atk_rate_q <= atk_rate_d;
            rel_rate_q <= rel_rate_d;
            scale_q    <= scale_d;
            active_q   <= active_d;
            done_q     <= done_d;
        end
    end

    assign scale  = scale_q;
    assign index  = index_q;
    assign active = active_q;
    assign done   = done_q;

endmodule

// File: tb/tb_exponential_envelope.sv
// Scoreboard bench for exponential_envelope: stimulus pushes the expected
// post-edge outputs, a negedge monitor pops and compares them.
module tb_exponential_envelope;

    logic       clk;
    logic       reset;
    logic       note_start;
    logic       note_hold;
    logic       sample_ready;
    logic [7:0] attack_rate;
    logic [7:0] release_rate;
    logic [7:0] scale;
    logic [3:0] index;
    logic       active;
    logic       done;

    exponential_envelope #(.ADDR_W(4), .DOUT_W(8), .RATE_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .note_start   (note_start),
        .note_hold    (note_hold),
        .sample_ready (sample_ready),
        .attack_rate  (attack_rate),
        .release_rate (release_rate),
        .scale        (scale),
        .index        (index),
        .active       (active),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int scen;
        int idx;
        int scl;
        bit act;
        bit dn;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int TBL [16] = '{255, 192, 128, 96, 64, 48, 32, 24, 16, 12, 8, 6, 4, 3, 2, 1};

    int n_checks = 0;
    int n_fail   = 0;
    int n_txn    = 0;
    int scen     = 0;
    int prev_idx = 15;
    bit prev_act = 1'b0;

    task automatic chk(input string name, input int act_v, input int exp_v);
        n_checks++;
        if (act_v != exp_v) begin
            n_fail++;
            $display("FAIL %s (scenario %0d, txn %0d): got %0d, expected %0d",
                     name, mon_e.scen, n_txn, act_v, exp_v);
        end
    endtask

    // Monitor: every cycle with a pending expectation is compared here.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            n_txn++;
            $display("txn %0d sc%0d: index=%0d scale=%0d active=%0d done=%0d",
                     n_txn, mon_e.scen, index, scale, active, done);
            chk("index",  int'(index),  mon_e.idx);
            chk("scale",  int'(scale),  mon_e.scl);
            chk("active", int'(active), int'(mon_e.act));
            chk("done",   int'(done),   int'(mon_e.dn));
        end
    end

    // One clock of stimulus; called at a negedge, returns at the next negedge.
    task automatic cyc(input bit rst, input bit st, input bit hold, input bit sr,
                       input int e_idx, input bit e_act, input bit e_done);
        exp_t e;
        reset        = rst;
        note_start   = st;
        note_hold    = hold;
        sample_ready = sr;
        @(posedge clk);
        e.scen = scen;
        e.idx  = e_idx;
        e.scl  = rst ? 0 : (prev_act ? TBL[prev_idx] : 0);
        e.act  = e_act;
        e.dn   = e_done;
        sb.push_back(e);
        prev_idx = e_idx;
        prev_act = e_act;
        @(negedge clk);
        reset        = 1'b0;
        note_start   = 1'b0;
        sample_ready = 1'b0;
    endtask

    // Bounded run time.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t, limit 200000", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset        = 1'b1;
        note_start   = 1'b0;
        note_hold    = 1'b0;
        sample_ready = 1'b0;
        attack_rate  = 8'd0;
        release_rate = 8'd0;

        // 1: reset for three cycles then idle
        scen = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        prev_idx = 15;
        prev_act = 1'b0;
        cyc(0, 0, 0, 0, 15, 0, 0);
        cyc(0, 0, 0, 1, 15, 0, 0);

        // 2: attack at rate 0, strobe every cycle, then sustain
        scen = 2;
        attack_rate  = 8'd0;
        release_rate = 8'd1;
        cyc(0, 1, 1, 1, 15, 1, 0);
        attack_rate  = 8'd5;   // must not affect the running note
        release_rate = 8'd0;
        for (int s = 1; s <= 15; s++) cyc(0, 0, 1, 1, 15 - s, 1, 0);
        for (int k = 0; k < 20; k++) cyc(0, 0, 1, 1, 0, 1, 0);

        // 3: release at latched rate 1
        scen = 3;
        cyc(0, 0, 0, 1, 0, 1, 0);
        for (int s = 1; s <= 31; s++) cyc(0, 0, 0, 1, s / 2, 1, 0);
        cyc(0, 0, 0, 1, 15, 0, 1);
        for (int k = 0; k < 3; k++) cyc(0, 0, 0, 1, 15, 0, 0);

        // 4: retrigger during release at index 9
        scen = 4;
        attack_rate  = 8'd0;
        release_rate = 8'd0;
        cyc(0, 1, 0, 0, 15, 1, 0);
        for (int s = 1; s <= 15; s++) cyc(0, 0, 0, 1, 15 - s, 1, 0);
        for (int r = 1; r <= 9; r++) cyc(0, 0, 0, 1, r, 1, 0);
        cyc(0, 1, 1, 1, 9, 1, 0);
        for (int s = 1; s <= 9; s++) cyc(0, 0, 1, 1, 9 - s, 1, 0);
        cyc(0, 0, 1, 0, 0, 1, 0);
        cyc(0, 0, 1, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 1, 0);
        for (int r = 1; r <= 15; r++) cyc(0, 0, 0, 1, r, 1, 0);
        cyc(0, 0, 0, 1, 15, 0, 1);
        cyc(0, 0, 0, 0, 15, 0, 0);

        // 5: short note, attack rate 2, sparse strobes, hold dropped early
        scen = 5;
        attack_rate  = 8'd2;
        release_rate = 8'd0;
        cyc(0, 1, 1, 0, 15, 1, 0);
        for (int s = 1; s <= 45; s++) begin
            cyc(0, 0, (s < 20), 0, 15 - (s - 1) / 3, 1, 0);
            cyc(0, 0, (s < 20), 1, 15 - s / 3, 1, 0);
        end
        for (int r = 1; r <= 15; r++) cyc(0, 0, 0, 1, r, 1, 0);
        cyc(0, 0, 0, 1, 15, 0, 1);
        cyc(0, 0, 0, 0, 15, 0, 0);

        // 6: start coincident with a strobe, then abort by reset mid-attack
        scen = 6;
        attack_rate = 8'd2;
        cyc(0, 1, 1, 1, 15, 1, 0);
        cyc(0, 0, 1, 1, 15, 1, 0);
        cyc(0, 0, 1, 1, 15, 1, 0);
        cyc(0, 0, 1, 1, 14, 1, 0);
        cyc(0, 0, 1, 1, 14, 1, 0);
        cyc(1, 0, 1, 1, 15, 0, 0);
        cyc(0, 0, 0, 0, 15, 0, 0);
        attack_rate = 8'd0;
        cyc(0, 1, 1, 0, 15, 1, 0);
        cyc(0, 0, 1, 1, 14, 1, 0);
        cyc(1, 0, 0, 0, 15, 0, 0);
        cyc(0, 0, 0, 0, 15, 0, 0);

        // Let the monitor drain the scoreboard.
        for (int w = 0; w < 5 && sb.size() != 0; w++) @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
